fp_accum: RTL and testbench
===========================

# fp_accum

Streaming single-precision accumulator that consumes the 32-bit products emitted by the floating-point multiplier stage and sums a packet of them into one IEEE-754-format result. Each accepted term passes through a fixed four-cycle align/add/normalize FSM. When the term flagged `in_last` completes, the block presents the packet sum downstream with a valid/ready handshake, then clears itself for the next packet. Together with the multiplier it forms the dot-product datapath.

## Interface
- `CNT_W`, default 8: width of the term counter; count saturates at 2^CNT_W−1.
- `clk`, in, 1: single clock; all state changes on rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `in_valid`, in, 1: `in_data`/`in_last` valid.
- `in_ready`, out, 1: block accepts a term this cycle.
- `in_data`, in, 32: term, IEEE single layout {sign, exp[7:0], frac[22:0]}.
- `in_last`, in, 1: term closes the packet.
- `out_valid`, out, 1: packet sum available.
- `out_ready`, in, 1: downstream takes the sum.
- `out_data`, out, 32: packet sum.
- `out_count`, out, CNT_W: terms accumulated in this packet.
- `out_ovf`, out, 1: saturation occurred at any point in this packet.

## Operation
- FSM states: IDLE, ALIGN, ADD, NORM, DONE.
- IDLE: `in_ready`=1. On `in_valid`: latch term and `in_last`, increment count (saturating), go to ALIGN.
- ALIGN: compare accumulator and term exponents. Right-shift the smaller mantissa (24 bits, hidden 1) by the difference, truncating shifted-out bits. A difference ≥25 makes the smaller mantissa 0. Go to ADD.
- ADD: 25-bit add or subtract by signs. For subtraction, the result takes the sign of the larger magnitude, with ties giving +0. Go to NORM.
- NORM:
  - If bit24 is set: shift right 1, exp+1.
  - Otherwise: shift left until bit23 is set (single-cycle leading-zero count), exp −= shift.
  - Zero mantissa, or exp ≤0 after shift: accumulator = 0x00000000.
  - exp ≥255: accumulator = {sign, 0x7F7FFFFF[30:0]}; set ovf.
  - Then go to DONE if the latched last flag is set, else IDLE.
- DONE: `out_valid`=1, `in_ready`=0. On `out_ready`: clear accumulator to +0, count to 0, ovf to 0; go to IDLE.
- Input exp field 0 (zero/denormal) is treated as ±0. Input exp field 255 is treated as a normal number; the result saturates as above.
- Rounding: truncation (toward zero) throughout.
- `out_data`, `out_count` and `out_ovf` are stable while `out_valid`=1.

## Timing
- Reset (`rst_n`=0 at an edge), from any state, including mid-term or in DONE:
  - state=IDLE, accumulator=+0, count=0, ovf=0.
  - `out_valid`=0, `out_data`=0, `out_count`=0, `out_ovf`=0, `in_ready`=1 from the first cycle after reset.
  - An in-flight term is discarded.
- Throughput: one term per 4 cycles. Accept at edge N; `in_ready` is high again from edge N+4.
- Latency: a last term accepted at edge N gives `out_valid`=1 from edge N+4.
- Handshake: `in_valid` may be held with changing data only while `in_ready`=0. A term transfers only on `in_valid`&`in_ready`.
- `out_ready` held high in DONE: the sum transfers on the first DONE cycle, and IDLE follows next cycle.
- `in_valid` during DONE is ignored; it is not accepted until IDLE.
- Single-term packet (first term has `in_last`): the output is that term after normalization, which leaves a normal number unchanged.

## Structure
- Package `fp_pkg`:
  - Field widths: SIGN=1, EXP_W=8, MANT_W=23.
  - `EXP_BIAS`=127, `FP_MAX_MAG`=31'h7F7FFFFF.
  - Typedef `fp32_t` as a packed struct {sign, exp, frac}.
  - State enum `acc_state_e`.
- The package is shared with the multiplier stage.
- Sub-module `fp_lzc`: combinational 25-bit leading-zero counter used by NORM.

## Test plan
- 0x3F800000 then 0x40000000 with `in_last` on the second term, `out_ready`=1 → `out_data`=0x40400000, `out_count`=2, `out_ovf`=0. `out_valid` rises 4 cycles after the second accept.
- 0x3FC00000 then 0xBFC00000 (last) → `out_data`=0x00000000, `out_count`=2.
- Single term 0xC0490FDB with `in_last` → `out_data`=0xC0490FDB, `out_count`=1.
- 0x7F7FFFFF then 0x7F7FFFFF (last) → `out_data`=0x7F7FFFFF, `out_ovf`=1.
- 0x3F800000 then 0x30800000 (2^-30, last) → `out_data`=0x3F800000, because the alignment shift is ≥25.
- Backpressure and reset:
  - Hold `out_ready`=0 for 5 cycles in DONE → `out_*` stable, `in_ready`=0. Raise `out_ready` → IDLE next cycle, and the next packet starts from +0.
  - Assert `rst_n`=0 during ADD → all outputs 0 and `in_ready`=1 the cycle after.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fp_pkg
// Brief   : Shared single-precision field layout, constants and FSM states
//           for the multiplier / accumulator dot-product datapath.
// Revision: 1.0  initial release
// ============================================================================
package fp_pkg;

    localparam int SIGN     = 1;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int EXP_BIAS = 127;
    localparam logic [30:0] FP_MAX_MAG = 31'h7F7FFFFF;

    typedef struct packed {
        logic [SIGN-1:0]   sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_DONE  = 3'd4
    } acc_state_e;

    // Zero/denormal exponent reads as zero; otherwise restore the hidden 1.
    function automatic logic [MANT_W:0] fp_mant(input fp32_t v);
        return (v.exp == '0) ? '0 : {1'b1, v.frac};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
// Module  : fp_lzc
// Brief   : Combinational 25-bit leading-zero counter (25 for an all-zero input).
// Revision: 1.0  initial release
// ============================================================================
module fp_lzc (
    input  logic [24:0] i_data,
    output logic [4:0]  o_cnt
);

    always_comb begin
        o_cnt = 5'd25;
        for (int i = 0; i < 25; i++) begin
            if (i_data[i]) begin
                o_cnt = 5'(24 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_accum.sv
`default_nettype none
// ============================================================================
// Module  : fp_accum
// Brief   : Streaming single-precision packet accumulator, truncating
//           align/add/normalize FSM with valid/ready output handshake.
// Revision: 1.0  initial release
// ============================================================================
module fp_accum
    import fp_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    acc_state_e       r_state;
    acc_state_e       w_state_nxt;
    fp32_t            r_acc;
    fp32_t            r_term;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [23:0]      r_ma;
    logic [23:0]      r_mt;
    logic             r_sa;
    logic             r_st;
    logic [7:0]       r_exp;
    logic [24:0]      r_sum;
    logic             r_sign;

    logic             w_accept;
    logic             w_acc_big;
    logic [7:0]       w_diff;
    logic [23:0]      w_small_sh;
    logic [24:0]      w_sum;
    logic             w_sign;
    logic [4:0]       w_lz;
    logic [4:0]       w_shl;
    logic [24:0]      w_norm_mant;
    logic signed [9:0] w_exp_n;
    logic             w_norm_zero;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = ST_ALIGN;
            end
            ST_ALIGN: w_state_nxt = ST_ADD;
            ST_ADD:   w_state_nxt = ST_NORM;
            ST_NORM:  w_state_nxt = r_last ? ST_DONE : ST_IDLE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    assign w_accept = in_valid & in_ready;

    // Alignment: the smaller operand is shifted toward the larger exponent.
    assign w_acc_big  = (r_acc.exp >= r_term.exp);
    assign w_diff     = w_acc_big ? (r_acc.exp - r_term.exp) : (r_term.exp - r_acc.exp);
    assign w_small_sh = (w_diff >= 8'd25) ? 24'd0
                      : ((w_acc_big ? fp_mant(r_term) : fp_mant(r_acc)) >> w_diff);

    always_comb begin
        w_sum  = '0;
        w_sign = 1'b0;
        if (r_sa == r_st) begin
            w_sum  = {1'b0, r_ma} + {1'b0, r_mt};
            w_sign = r_sa;
        end else if (r_ma > r_mt) begin
            w_sum  = {1'b0, r_ma - r_mt};
            w_sign = r_sa;
        end else if (r_mt > r_ma) begin
            w_sum  = {1'b0, r_mt - r_ma};
            w_sign = r_st;
        end
    end

    fp_lzc u_lzc (
        .i_data (r_sum),
        .o_cnt  (w_lz)
    );

    // Target is bit23, one below the MSB, so the left shift is lz-1.
    assign w_shl       = (w_lz == 5'd0) ? 5'd0 : (w_lz - 5'd1);
    assign w_norm_mant = r_sum[24] ? (r_sum >> 1) : (r_sum << w_shl);
    assign w_exp_n     = r_sum[24] ? ($signed({2'b00, r_exp}) + 10'sd1)
                                   : ($signed({2'b00, r_exp}) - $signed({5'b00000, w_shl}));
    assign w_norm_zero = (r_sum == 25'd0) || (w_exp_n <= 10'sd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_term <= '0;
            r_last <= 1'b0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_ma   <= '0;
            r_mt   <= '0;
            r_sa   <= 1'b0;
            r_st   <= 1'b0;
            r_exp  <= '0;
            r_sum  <= '0;
            r_sign <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_term <= fp32_t'(in_data);
                        r_last <= in_last;
                        if (&r_cnt) r_ovf <= 1'b1;
                        else        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_ALIGN: begin
                    r_sa  <= r_acc.sign;
                    r_st  <= r_term.sign;
                    r_exp <= w_acc_big ? r_acc.exp : r_term.exp;
                    r_ma  <= w_acc_big ? fp_mant(r_acc) : w_small_sh;
                    r_mt  <= w_acc_big ? w_small_sh : fp_mant(r_term);
                end
                ST_ADD: begin
                    r_sum  <= w_sum;
                    r_sign <= w_sign;
                end
                ST_NORM: begin
                    if (w_norm_zero) begin
                        r_acc <= '0;
                    end else if (w_exp_n >= 10'sd255) begin
                        r_acc <= fp32_t'({r_sign, FP_MAX_MAG});
                        r_ovf <= 1'b1;
                    end else begin
                        r_acc <= fp32_t'({r_sign, w_exp_n[7:0], w_norm_mant[22:0]});
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data  = r_acc;
    assign out_count = r_cnt;
    assign out_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fp_accum.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp_accum
// Brief   : Directed, table-driven self-checking bench for fp_accum.
// Revision: 1.0  initial release
// ============================================================================
module tb_fp_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_count;
    logic        out_ovf;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        string       name;
        int          n;
        logic [31:0] t0;
        logic [31:0] t1;
        logic [31:0] t2;
        logic [31:0] exp_data;
        logic [7:0]  exp_cnt;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[13];

    fp_accum #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
        end
    endtask

    // Waits on negedges until the chosen output rises; returns cycles waited.
    task automatic wait_high(input bit use_valid, output int cyc);
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            cyc++;
            if (use_valid ? out_valid : in_ready) break;
        end
    endtask

    task automatic send_term(input logic [31:0] d, input logic l);
        int budget;
        budget = 0;
        while (!in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_packet(input vec_t v);
        logic [31:0] t;
        int          cyc;
        for (int i = 0; i < v.n; i++) begin
            t = (i == 0) ? v.t0 : (i == 1) ? v.t1 : v.t2;
            send_term(t, (i == v.n - 1));
            if (i != v.n - 1) begin
                wait_high(1'b0, cyc);
                chk({v.name, "_ready_gap"}, cyc, 4);
            end
        end
        wait_high(1'b1, cyc);
        chk({v.name, "_latency"}, cyc, 4);
        chk({v.name, "_data"}, out_data, v.exp_data);
        chk({v.name, "_count"}, {24'd0, out_count}, {24'd0, v.exp_cnt});
        chk({v.name, "_ovf"}, {31'd0, out_ovf}, {31'd0, v.exp_ovf});
        if (out_ready) begin
            @(negedge clk);
            chk({v.name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
            chk({v.name, "_ready_back"}, {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        vec_t v;
        int   cyc;

        vecs[0]  = '{"add_1_2",     2, 32'h3F800000, 32'h40000000, 32'h0, 32'h40400000, 8'd2, 1'b0};
        vecs[1]  = '{"cancel",      2, 32'h3FC00000, 32'hBFC00000, 32'h0, 32'h00000000, 8'd2, 1'b0};
        vecs[2]  = '{"single_negpi",1, 32'hC0490FDB, 32'h0,        32'h0, 32'hC0490FDB, 8'd1, 1'b0};
        vecs[3]  = '{"sat_pos",     2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 32'h7F7FFFFF, 8'd2, 1'b1};
        vecs[4]  = '{"shift30",     2, 32'h3F800000, 32'h30800000, 32'h0, 32'h3F800000, 8'd2, 1'b0};
        vecs[5]  = '{"shift24",     2, 32'h3F800000, 32'h33800000, 32'h0, 32'h3F800000, 8'd2, 1'b0};
        vecs[6]  = '{"shift23",     2, 32'h3F800000, 32'h34000000, 32'h0, 32'h3F800001, 8'd2, 1'b0};
        vecs[7]  = '{"sub_norm",    2, 32'h3F800000, 32'hBF400000, 32'h0, 32'h3E800000, 8'd2, 1'b0};
        vecs[8]  = '{"neg_neg",     2, 32'hBF800000, 32'hBF800000, 32'h0, 32'hC0000000, 8'd2, 1'b0};
        vecs[9]  = '{"three_terms", 3, 32'h3F800000, 32'h40000000, 32'h40800000, 32'h40E00000, 8'd3, 1'b0};
        vecs[10] = '{"underflow",   2, 32'h00C00000, 32'h80800000, 32'h0, 32'h00000000, 8'd2, 1'b0};
        vecs[11] = '{"denorm_in",   1, 32'h00000001, 32'h0,        32'h0, 32'h00000000, 8'd1, 1'b0};
        vecs[12] = '{"sat_neg",     2, 32'hFF7FFFFF, 32'hFF7FFFFF, 32'h0, 32'hFF7FFFFF, 8'd2, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  out_data,           32'd0);
        chk("rst_out_count", {24'd0, out_count}, 32'd0);
        chk("rst_out_ovf",   {31'd0, out_ovf},   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_packet(vecs[i]);
        end

        // Backpressure: sum held in DONE; a term offered meanwhile is ignored.
        out_ready = 1'b0;
        send_term(32'h3F800000, 1'b1);
        wait_high(1'b1, cyc);
        chk("bp_latency", cyc, 4);
        in_valid = 1'b1;
        in_data  = 32'h40000000;
        in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
            chk("bp_data_hold",  out_data,           32'h3F800000);
            chk("bp_count_hold", {24'd0, out_count}, 32'd1);
            chk("bp_in_ready",   {31'd0, in_ready},  32'd0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, in_ready},  32'd1);
        chk("bp_cleared_data",  out_data,           32'd0);
        chk("bp_cleared_count", {24'd0, out_count}, 32'd0);
        v = '{"after_bp", 1, 32'h40000000, 32'h0, 32'h0, 32'h40000000, 8'd1, 1'b0};
        run_packet(v);

        // Reset while the second term of a packet sits in ADD.
        send_term(32'h3F800000, 1'b0);
        wait_high(1'b0, cyc);
        send_term(32'h40000000, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_count", {24'd0, out_count}, 32'd2);
        chk("pre_rst_data",  out_data,           32'h3F800000);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_data",  out_data,           32'd0);
        chk("midrst_out_count", {24'd0, out_count}, 32'd0);
        chk("midrst_out_ovf",   {31'd0, out_ovf},   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        v = '{"after_rst", 1, 32'h40000000, 32'h0, 32'h0, 32'h40000000, 8'd1, 1'b0};
        run_packet(v);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
